// File: rtl/piso_tx_arbiter.sv
// piso_tx_arbiter: round-robin arbiter sharing one MSB-first PISO serialiser between NREQ requesters
// Ports: clk, clr (async active-low reset), req[NREQ], data_in[NREQ*WIDTH],
//        grant[NREQ], ack[NREQ], busy, sout, sout_valid, frame_start
// Option: define PISO_ARB_PARITY_EN to append an even-parity bit to every frame
module piso_tx_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  sout,
  output logic                  sout_valid,
  output logic                  frame_start
);
`ifdef PISO_ARB_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif
  localparam int CW = $clog2(FW);
  localparam int LW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, n_state;
  logic [FW-1:0] shreg, n_shreg, load;
  logic [CW-1:0] cnt, n_cnt;
  logic [LW-1:0] last, n_last, win;
  logic [NREQ-1:0] n_grant, n_ack;
  logic n_sout, n_valid, n_fs, found;
  logic [WIDTH-1:0] word;
  int idx;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!found && req[idx]) begin
        win = LW'(idx);
        found = 1'b1;
      end
    end
  end
  assign word = data_in[int'(win)*WIDTH +: WIDTH];
`ifdef PISO_ARB_PARITY_EN
  assign load = {word, ^word};
`else
  assign load = word;
`endif
  assign busy = state != IDLE;
  always_comb begin
    n_state = state;
    n_shreg = shreg;
    n_cnt   = cnt;
    n_last  = last;
    n_grant = grant;
    n_ack   = '0;
    n_sout  = sout;
    n_valid = sout_valid;
    n_fs    = 1'b0;
    case (state)
      IDLE: if (|req) begin
        n_shreg = load;
        n_grant = NREQ'(1) << win;
        n_last  = win;
        n_cnt   = CW'(FW - 1);
        n_sout  = load[FW-1];
        n_valid = 1'b1;
        n_fs    = 1'b1;
        n_state = SHIFT;
      end
      SHIFT: if (cnt != '0) begin
        n_shreg = shreg << 1;
        n_sout  = shreg[FW-2];
        n_cnt   = cnt - 1'b1;
      end else begin
        n_valid = 1'b0;
        n_sout  = 1'b0;
        n_ack   = grant;
        n_grant = '0;
        n_state = DONE;
      end
      default: n_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      last        <= LW'(NREQ - 1);
      grant       <= '0;
      ack         <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= n_state;
      shreg       <= n_shreg;
      cnt         <= n_cnt;
      last        <= n_last;
      grant       <= n_grant;
      ack         <= n_ack;
      sout        <= n_sout;
      sout_valid  <= n_valid;
      frame_start <= n_fs;
    end
  end
endmodule

// File: tb/tb_piso_tx_arbiter.sv
// tb_piso_tx_arbiter: scoreboard-driven directed bench for piso_tx_arbiter
module tb_piso_tx_arbiter;
`ifdef PISO_ARB_PARITY_EN
  localparam int FW = 5;
`else
  localparam int FW = 4;
`endif
  logic clk = 1'b0, clr = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] data_in = '0;
  logic [1:0] grant, ack;
  logic busy, sout, sout_valid, frame_start;
  int passed = 0, total = 0, cyc = 0, prev_cyc = 0;
  typedef struct {int id; logic [3:0] word;} item_t;
  item_t sb[$];
  piso_tx_arbiter #(.WIDTH(4), .NREQ(2)) dut (
    .clk(clk), .clr(clr), .req(req), .data_in(data_in), .grant(grant), .ack(ack),
    .busy(busy), .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [FW-1:0] exp_bits(input logic [3:0] w);
`ifdef PISO_ARB_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic idle_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sout"}, sout, 0);
    chk({tag, "_valid"}, sout_valid, 0);
    chk({tag, "_fs"}, frame_start, 0);
  endtask
  task automatic wait_fs();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 20);
    chk("frame_start_seen", frame_start, 1);
  endtask
  task automatic run_frame(input bit drop, input bit rel, input bit spacing);
    item_t it;
    logic [FW-1:0] eb;
    logic [1:0] oh;
    it = sb.pop_front();
    eb = exp_bits(it.word);
    oh = 2'b01 << it.id;
    wait_fs();
    if (spacing) chk("frame_spacing", cyc - prev_cyc, FW + 2);
    prev_cyc = cyc;
    for (int b = 0; b < FW; b++) begin
      if (b > 0) @(negedge clk);
      chk("sout_bit", sout, eb[FW-1-b]);
      chk("sout_valid", sout_valid, 1);
      chk("grant", grant, oh);
      chk("busy", busy, 1);
      chk("frame_start_pulse", frame_start, b == 0);
      if (drop && b == 0) req[it.id] = 1'b0;
    end
    @(negedge clk);
    chk("ack_pulse", ack, oh);
    chk("grant_end", grant, 0);
    chk("valid_end", sout_valid, 0);
    chk("sout_end", sout, 0);
    if (rel) req = 2'b00;
    @(negedge clk);
    chk("ack_clear", ack, 0);
    chk("busy_idle", busy, 0);
  endtask
  initial begin
    req = 2'b11;
    data_in = {4'b0101, 4'b1010};
    repeat (3) begin
      @(negedge clk);
      idle_zero("reset");
    end
    req = 2'b00;
    clr = 1'b1;
    @(negedge clk);
    idle_zero("post_reset");
    req = 2'b01;
    sb.push_back('{0, 4'b1010});
    run_frame(1'b0, 1'b1, 1'b0);
    data_in = {4'b0101, 4'b1100};
    req = 2'b01;
    sb.push_back('{0, 4'b1100});
    run_frame(1'b1, 1'b0, 1'b0);
    data_in = {4'b0101, 4'b1010};
    req = 2'b01;
    wait_fs();
    chk("abort_bit0", sout, 1);
    @(negedge clk);
    chk("abort_bit1", sout, 0);
    #2 clr = 1'b0;
    #1 idle_zero("abort");
    req = 2'b10;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_ack", ack, 0);
      chk("abort_busy", busy, 0);
    end
    clr = 1'b1;
    sb.push_back('{1, 4'b0101});
    run_frame(1'b0, 1'b1, 1'b0);
    req = 2'b11;
    sb.push_back('{0, 4'b1010});
    sb.push_back('{1, 4'b0101});
    sb.push_back('{0, 4'b1010});
    sb.push_back('{1, 4'b0101});
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b1, 1'b1);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
